// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave register file: RW control bank plus RO status bank.
// Independent AW/W capture, byte strobes, SLVERR/DECERR, write pulses.
module axil_regfile_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RW     = 4,
  parameter int NUM_RO     = 2,
  parameter int ADDR_WIDTH = 6,
  parameter logic [NUM_RW*DATA_WIDTH-1:0] RW_RESET = '0
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [NUM_RW*DATA_WIDTH-1:0] ctrl_regs,
  input  logic [(NUM_RO>0?NUM_RO:1)*DATA_WIDTH-1:0] status_in,
  output logic [NUM_RW-1:0]       wr_pulse
);

  localparam int STRB_W   = DATA_WIDTH/8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

  logic [NUM_RW*DATA_WIDTH-1:0] r_regs;
  logic [NUM_RW-1:0]  r_wr_pulse;
  logic               r_awready, r_wready, r_bvalid;
  logic               r_aw_held, r_w_held;
  logic [IDX_W-1:0]   r_awidx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]  r_wstrb;
  logic [1:0]         r_bresp;
  logic               r_arready, r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]         r_rresp;

  logic               w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic               w_bvalid_nxt, w_aw_held_nxt, w_w_held_nxt;
  logic               w_rvalid_nxt;
  logic [IDX_W-1:0]   w_widx, w_ridx;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_W-1:0]  w_wstrb;
  logic [NUM_RW*DATA_WIDTH-1:0] w_regs_nxt;
  logic [NUM_RW-1:0]  w_pulse_nxt;
  logic [DATA_WIDTH-1:0] w_rdata_sel;
  logic [1:0]         w_rresp_sel;
  logic               w_unused;

  function automatic logic [1:0] f_wresp(input logic [IDX_W-1:0] idx);
    if (int'(idx) < NUM_RW) return 2'b00;
    else if (int'(idx) < NUM_RW + NUM_RO) return 2'b10;
    else return 2'b11;
  endfunction

  assign w_aw_hs  = S_AXI_AWVALID & r_awready;
  assign w_w_hs   = S_AXI_WVALID & r_wready;
  assign w_ar_hs  = S_AXI_ARVALID & r_arready;
  assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

  // Held beats take priority; otherwise use the beat handshaking now
  assign w_widx  = r_aw_held ? r_awidx
                             : S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign w_wdata = r_w_held ? r_wdata : S_AXI_WDATA;
  assign w_wstrb = r_w_held ? r_wstrb : S_AXI_WSTRB;
  assign w_ridx  = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];

  assign w_bvalid_nxt  = w_commit | (r_bvalid & ~S_AXI_BREADY);
  assign w_aw_held_nxt = ~w_commit & (r_aw_held | w_aw_hs);
  assign w_w_held_nxt  = ~w_commit & (r_w_held | w_w_hs);
  assign w_rvalid_nxt  = w_ar_hs | (r_rvalid & ~S_AXI_RREADY);

  always_comb begin
    w_regs_nxt  = r_regs;
    w_pulse_nxt = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (w_commit && w_widx == IDX_W'(i)) begin
        w_pulse_nxt[i] = 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (w_wstrb[b])
            w_regs_nxt[i*DATA_WIDTH+b*8 +: 8] = w_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    w_rdata_sel = '0;
    w_rresp_sel = 2'b11;
    for (int i = 0; i < NUM_RW; i++) begin
      if (w_ridx == IDX_W'(i)) begin
        w_rdata_sel = r_regs[i*DATA_WIDTH +: DATA_WIDTH];
        w_rresp_sel = 2'b00;
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (w_ridx == IDX_W'(NUM_RW + j)) begin
        w_rdata_sel = status_in[j*DATA_WIDTH +: DATA_WIDTH];
        w_rresp_sel = 2'b00;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_regs     <= RW_RESET;
      r_wr_pulse <= '0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awidx    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= 2'b00;
    end else begin
      r_regs     <= w_regs_nxt;
      r_wr_pulse <= w_pulse_nxt;
      r_aw_held  <= w_aw_held_nxt;
      r_w_held   <= w_w_held_nxt;
      r_bvalid   <= w_bvalid_nxt;
      r_awready  <= ~w_aw_held_nxt & ~w_bvalid_nxt;
      r_wready   <= ~w_w_held_nxt & ~w_bvalid_nxt;
      if (w_aw_hs) r_awidx <= S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) r_bresp <= f_wresp(w_widx);
      r_rvalid  <= w_rvalid_nxt;
      r_arready <= ~w_rvalid_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_rdata_sel;
        r_rresp <= w_rresp_sel;
      end
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign ctrl_regs     = r_regs;
  assign wr_pulse      = r_wr_pulse;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[ADDR_LSB-1:0],
                      S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Bench for axil_regfile_slave: vector table, corner sequences,
// and random traffic against an array-based reference model.
module tb_axil_regfile_slave;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [127:0] ctrl_regs;
  logic [63:0] status_in;
  logic [3:0] wr_pulse;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [4];
  int epc [4];
  int pcnt [4];

  always #5 clk = ~clk;

  axil_regfile_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl_regs(ctrl_regs), .status_in(status_in),
    .wr_pulse(wr_pulse)
  );

  always @(negedge clk)
    for (int i = 0; i < 4; i++) if (wr_pulse[i]) pcnt[i]++;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s,
                             output logic [1:0] resp);
    int idx = int'(a) / 4;
    if (idx < 4) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
      epc[idx]++;
      resp = 2'b00;
    end else if (idx < 6) resp = 2'b10;
    else resp = 2'b11;
  endtask

  task automatic model_read(input logic [5:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
    int idx = int'(a) / 4;
    resp = 2'b00;
    if (idx < 4) d = model[idx];
    else if (idx == 4) d = status_in[31:0];
    else if (idx == 5) d = status_in[63:32];
    else begin d = 32'h0; resp = 2'b11; end
  endtask

  function automatic logic [127:0] mpack();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = model[i];
    return r;
  endfunction

  // Entered and left at posedge+1
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int dly,
                           output logic [1:0] resp);
    logic ad, wd, ha, hw, ok;
    awaddr = a; wdata = d; wstrb = s; awprot = 3'($urandom);
    awvalid = 1'b1; wvalid = 1'b1;
    ad = 1'b0; wd = 1'b0; ok = 1'b0; resp = 2'bxx;
    for (int c = 0; c < 40 && !(ad && wd); c++) begin
      @(negedge clk);
      ha = awvalid & awready; hw = wvalid & wready;
      @(posedge clk); #1;
      if (ha) begin awvalid = 1'b0; ad = 1'b1; end
      if (hw) begin wvalid = 1'b0; wd = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (dly) @(posedge clk);
    #1 bready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bvalid) begin
        resp = bresp; ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
    end
    bready = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL wr_timeout: got no BVALID want BVALID addr %0h", a);
    end
  endtask

  task automatic axi_read(input logic [5:0] a, input int dly,
                          output logic [31:0] d, output logic [1:0] resp);
    logic ha, ok;
    araddr = a; arprot = 3'($urandom); arvalid = 1'b1;
    ok = 1'b0; d = 'x; resp = 2'bxx; ha = 1'b0;
    for (int c = 0; c < 40 && !ha; c++) begin
      @(negedge clk);
      ha = arvalid & arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    repeat (dly) @(posedge clk);
    #1 rready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rvalid) begin
        d = rdata; resp = rresp; ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
    end
    rready = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL rd_timeout: got no RVALID want RVALID addr %0h", a);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [1:0] r, mr;
    logic [31:0] d, md;
    logic hs;

    tbl[0]  = '{1'b1, 6'h00, 32'h1,        4'hF, 2'b00, 32'h0};
    tbl[1]  = '{1'b1, 6'h04, 32'h2,        4'hF, 2'b00, 32'h0};
    tbl[2]  = '{1'b1, 6'h08, 32'h3,        4'hF, 2'b00, 32'h0};
    tbl[3]  = '{1'b1, 6'h0C, 32'h4,        4'hF, 2'b00, 32'h0};
    tbl[4]  = '{1'b0, 6'h00, 32'h0,        4'h0, 2'b00, 32'h1};
    tbl[5]  = '{1'b0, 6'h04, 32'h0,        4'h0, 2'b00, 32'h2};
    tbl[6]  = '{1'b0, 6'h08, 32'h0,        4'h0, 2'b00, 32'h3};
    tbl[7]  = '{1'b0, 6'h0C, 32'h0,        4'h0, 2'b00, 32'h4};
    tbl[8]  = '{1'b1, 6'h00, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0};
    tbl[9]  = '{1'b1, 6'h00, 32'h12345678, 4'h5, 2'b00, 32'h0};
    tbl[10] = '{1'b0, 6'h00, 32'h0,        4'h0, 2'b00, 32'hFF34FF78};
    tbl[11] = '{1'b1, 6'h10, 32'hDEADBEEF, 4'hF, 2'b10, 32'h0};
    tbl[12] = '{1'b0, 6'h10, 32'h0,        4'h0, 2'b00, 32'hCAFE0001};
    tbl[13] = '{1'b0, 6'h14, 32'h0,        4'h0, 2'b00, 32'h5A5A0002};
    tbl[14] = '{1'b0, 6'h3C, 32'h0,        4'h0, 2'b11, 32'h0};
    tbl[15] = '{1'b1, 6'h3C, 32'h9,        4'hF, 2'b11, 32'h0};
    tbl[16] = '{1'b1, 6'h04, 32'hFFFF,     4'h0, 2'b00, 32'h0};
    tbl[17] = '{1'b0, 6'h06, 32'h0,        4'h0, 2'b00, 32'h2};

    for (int i = 0; i < 4; i++) begin model[i] = '0; epc[i] = 0; end
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0;
    status_in = {32'h5A5A0002, 32'hCAFE0001};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {awready, wready, bvalid, arready, rvalid,
                     bresp, rresp, wr_pulse}, '0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_regs", ctrl_regs, 128'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy0", {awready, wready, arready}, 3'b000);
    @(negedge clk);
    chk("rel_rdy1", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3, r);
        model_write(tbl[i].addr, tbl[i].data, tbl[i].strb, mr);
        chk($sformatf("tbl%0d_bresp", i), r, tbl[i].resp);
      end else begin
        axi_read(tbl[i].addr, i % 2, d, r);
        chk($sformatf("tbl%0d_rresp", i), r, tbl[i].resp);
        chk($sformatf("tbl%0d_rdata", i), d, tbl[i].rdata);
      end
    end
    chk("tbl_regs", ctrl_regs,
        {32'h4, 32'h3, 32'h2, 32'hFF34FF78});
    chk("tbl_pulses", {pcnt[3], pcnt[2], pcnt[1], pcnt[0]},
        {32'd1, 32'd1, 32'd2, 32'd3});

    // W three cycles ahead of AW
    awaddr = 6'h08; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    wvalid = 1'b1;
    @(negedge clk); chk("wE_wready", wready, 1'b1);
    @(posedge clk); #1 wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("wE_idle%0d", c), {bvalid, wready}, 2'b00);
      @(posedge clk); #1;
    end
    awvalid = 1'b1;
    @(negedge clk); chk("wE_awready", awready, 1'b1);
    @(posedge clk); #1 awvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    chk("wE_b", {bvalid, bresp, wr_pulse}, 7'b1_00_0100);
    @(posedge clk); #1 bready = 1'b0;
    model_write(6'h08, 32'hA5A5A5A5, 4'hF, mr);
    @(negedge clk);
    chk("wE_reg", {bvalid, ctrl_regs[95:64]}, {1'b0, 32'hA5A5A5A5});
    @(posedge clk); #1;

    // B back-pressure on an SLVERR response
    awaddr = 6'h14; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_b%0d", c), {bvalid, bresp, awready, wready},
          5'b1_10_00);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    axi_write(6'h0C, 32'h11223344, 4'hF, 0, r);
    model_write(6'h0C, 32'h11223344, 4'hF, mr);
    chk("bp_next", {r, ctrl_regs[127:96]}, {2'b00, 32'h11223344});
    axi_read(6'h14, 0, d, r);
    chk("ro_keep", {r, d}, {2'b00, 32'h5A5A0002});

    // R back-pressure
    araddr = 6'h0C; arvalid = 1'b1;
    @(negedge clk); chk("rp_arready", arready, 1'b1);
    @(posedge clk); #1 arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("rp_r%0d", c), {rvalid, rresp, arready, rdata},
          {4'b1_00_0, 32'h11223344});
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    chk("rp_after", {rvalid, arready}, 2'b01);
    @(posedge clk); #1;

    // Read and write of reg0 at the same edge
    awaddr = 6'h00; araddr = 6'h00; wdata = 32'h0BADF00D; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    @(negedge clk);
    chk("rw_rdy", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1 awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    chk("rw_resp", {bvalid, bresp, rvalid, rresp}, 6'b1_00_1_00);
    chk("rw_old", rdata, 32'hFF34FF78);
    @(posedge clk); #1 bready = 0; rready = 0;
    model_write(6'h00, 32'h0BADF00D, 4'hF, mr);
    @(negedge clk);
    chk("rw_new", ctrl_regs[31:0], 32'h0BADF00D);
    @(posedge clk); #1;

    // Reset right after an AW handshake, W never sent
    awaddr = 6'h04; awvalid = 1'b1;
    @(negedge clk); chk("rm_awready", awready, 1'b1);
    @(posedge clk); #1 awvalid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rm_outs", {awready, wready, bvalid, arready, rvalid,
                    wr_pulse}, '0);
    chk("rm_regs", ctrl_regs, 128'h0);
    for (int i = 0; i < 4; i++) model[i] = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 6 && !hs; c++) begin
      @(negedge clk); hs = wready;
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    chk("rm_w_hs", hs, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rm_nob%0d", c), {bvalid, wr_pulse}, 5'b0);
      @(posedge clk); #1;
    end
    awaddr = 6'h04; awvalid = 1'b1; bready = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 6 && !hs; c++) begin
      @(negedge clk); hs = awready;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    @(negedge clk);
    chk("rm_b", {hs, bvalid, bresp}, 4'b1_1_00);
    @(posedge clk); #1 bready = 1'b0;
    model_write(6'h04, 32'h77, 4'hF, mr);
    chk("rm_regs2", ctrl_regs, mpack());

    // Random traffic against the model
    for (int n = 0; n < 80; n++) begin
      logic [5:0] a;
      logic [31:0] wd;
      logic [3:0] s;
      a = 6'($urandom_range(0, 63));
      wd = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        status_in = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, wd, s, $urandom_range(0, 3), r);
        model_write(a, wd, s, mr);
        chk($sformatf("rnd%0d_bresp", n), r, mr);
        chk($sformatf("rnd%0d_regs", n), ctrl_regs, mpack());
      end else begin
        axi_read(a, $urandom_range(0, 3), d, r);
        model_read(a, md, mr);
        chk($sformatf("rnd%0d_rresp", n), r, mr);
        chk($sformatf("rnd%0d_rdata", n), d, md);
      end
    end
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("pulse_cnt%0d", i), pcnt[i], epc[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
